core_mem_arb: RTL

CORE_MEM_ARB -- requirements
Module: core_mem_arb

---
 rtl/core_mem_arb_pkg.sv | 37 +++
 rtl/core_mem_arb_if.sv | 30 +++
 rtl/core_mem_arb_prio.sv | 27 ++
 rtl/core_mem_arb.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/core_mem_arb_pkg.sv
// Shared definitions for the core memory arbiter slice.
// Provides the arbiter state encoding, requester IDs (index into one-hot
// grant/ack vectors), the latched command kinds, active-low strobe levels
// and a width helper for the DMA starvation counter.
package core_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DATA  = 2'd1,
    DMA   = 2'd2
  } req_id_t;

  typedef enum logic [1:0] {
    CMD_ROM_RD = 2'd0,
    CMD_RAM_RD = 2'd1,
    CMD_RAM_WR = 2'd2
  } cmd_t;

  localparam int unsigned NUM_REQ = 3;

  // Strobes toward core_mem_ctrl are active-low.
  localparam logic ENABLE  = 1'b0;
  localparam logic DISABLE = 1'b1;

  // Bits needed to hold 0..max_val (at least one).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/core_mem_arb_if.sv
// Arbiter <-> core_mem_ctrl bus.
// master (arbiter): drives strobes, qualifiers, addresses and write data;
//                   receives ROM/RAM read data.
// slave  (core_mem_ctrl): the mirror image.
interface core_mem_arb_if;
  logic        mem_arb_rom_rd_b_o;
  logic        mem_arb_ram_rd_b_o;
  logic        mem_arb_ram_wr_b_o;
  logic        mem_arb_bit_byte_flag_o;
  logic        mem_arb_ext_ram_o;
  logic [15:0] mem_arb_rom_addr_o;
  logic [7:0]  mem_arb_ram_addr_o;
  logic [7:0]  mem_arb_ram_data_o;
  logic [7:0]  mem_arb_rom_data_i;
  logic [7:0]  mem_arb_ram_data_i;

  modport master (
    output mem_arb_rom_rd_b_o, mem_arb_ram_rd_b_o, mem_arb_ram_wr_b_o,
    output mem_arb_bit_byte_flag_o, mem_arb_ext_ram_o,
    output mem_arb_rom_addr_o, mem_arb_ram_addr_o, mem_arb_ram_data_o,
    input  mem_arb_rom_data_i, mem_arb_ram_data_i
  );

  modport slave (
    input  mem_arb_rom_rd_b_o, mem_arb_ram_rd_b_o, mem_arb_ram_wr_b_o,
    input  mem_arb_bit_byte_flag_o, mem_arb_ext_ram_o,
    input  mem_arb_rom_addr_o, mem_arb_ram_addr_o, mem_arb_ram_data_o,
    output mem_arb_rom_data_i, mem_arb_ram_data_i
  );
endinterface

// File: rtl/core_mem_arb_prio.sv
// Combinational priority selector for the memory arbiter.
// Inputs : fetch/data/dma request levels, current DMA starvation count.
// Output : one-hot grant indexed by req_id_t (all zero when nobody asks).
// Order is data > fetch > DMA, except a DMA that has lost DMA_STARVE
// arbitrations in a row wins outright.
module core_mem_arb_prio
  import core_mem_pkg::*;
#(
  parameter int unsigned DMA_STARVE = 8,
  parameter int unsigned CNT_W      = cnt_width(DMA_STARVE)
) (
  input  logic               fetch_req,
  input  logic               data_req,
  input  logic               dma_req,
  input  logic [CNT_W-1:0]   starve_cnt,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    grant = '0;
    if (dma_req && starve_cnt == CNT_W'(DMA_STARVE)) grant[DMA]   = 1'b1;
    else if (data_req)                               grant[DATA]  = 1'b1;
    else if (fetch_req)                              grant[FETCH] = 1'b1;
    else if (dma_req)                                grant[DMA]   = 1'b1;
  end

endmodule

// File: rtl/core_mem_arb.sv
// Core memory arbiter: shares core_mem_ctrl between instruction fetch,
// CPU data access and DMA.
// Ports: clk / async active-low reset; fetch, data and DMA request groups
// with one-cycle ack pulses; registered read data; ea_b (external program
// memory); "mem" bus (master modport) toward core_mem_ctrl.
// Flow: IDLE -> STROBE (-> WAIT for EXT_WAIT cycles when external) -> ACK.
module core_mem_arb
  import core_mem_pkg::*;
#(
  parameter int unsigned EXT_WAIT   = 2,
  parameter int unsigned DMA_STARVE = 8
) (
  input  logic        mem_arb_clk_i,
  input  logic        mem_arb_rst_b_i,
  input  logic        mem_arb_fetch_req_i,
  input  logic [15:0] mem_arb_fetch_addr_i,
  input  logic        mem_arb_data_req_i,
  input  logic        mem_arb_data_wr_i,
  input  logic        mem_arb_data_ext_i,
  input  logic        mem_arb_data_bit_i,
  input  logic [7:0]  mem_arb_data_addr_i,
  input  logic [7:0]  mem_arb_data_wdata_i,
  input  logic        mem_arb_dma_req_i,
  input  logic        mem_arb_dma_wr_i,
  input  logic [7:0]  mem_arb_dma_addr_i,
  input  logic [7:0]  mem_arb_dma_wdata_i,
  input  logic        mem_arb_ea_b_i,
  output logic        mem_arb_fetch_ack_o,
  output logic        mem_arb_data_ack_o,
  output logic        mem_arb_dma_ack_o,
  output logic [7:0]  mem_arb_rdata_o,
  core_mem_arb_if.master mem
);

  localparam int unsigned CNT_W = cnt_width(DMA_STARVE);

  state_t               state;
  req_id_t              owner;
  cmd_t                 cmd;
  logic                 ext_acc;
  logic [2:0]           wait_cnt;
  logic [CNT_W-1:0]     starve_cnt;
  logic [NUM_REQ-1:0]   grant;
  logic                 last_low;

  core_mem_arb_prio #(
    .DMA_STARVE (DMA_STARVE),
    .CNT_W      (CNT_W)
  ) u_prio (
    .fetch_req  (mem_arb_fetch_req_i),
    .data_req   (mem_arb_data_req_i),
    .dma_req    (mem_arb_dma_req_i),
    .starve_cnt (starve_cnt),
    .grant      (grant)
  );

  // High during the final strobe-low cycle; read data is captured and the
  // ack raised on the edge that ends it.
  assign last_low = (state == ST_STROBE && !(ext_acc && EXT_WAIT != 0)) ||
                    (state == ST_WAIT && wait_cnt == '0);

  always_ff @(posedge mem_arb_clk_i or negedge mem_arb_rst_b_i) begin
    if (!mem_arb_rst_b_i) begin
      state                       <= ST_IDLE;
      owner                       <= FETCH;
      cmd                         <= CMD_ROM_RD;
      ext_acc                     <= 1'b0;
      wait_cnt                    <= '0;
      starve_cnt                  <= '0;
      mem_arb_fetch_ack_o         <= 1'b0;
      mem_arb_data_ack_o          <= 1'b0;
      mem_arb_dma_ack_o           <= 1'b0;
      mem_arb_rdata_o             <= '0;
      mem.mem_arb_rom_rd_b_o      <= DISABLE;
      mem.mem_arb_ram_rd_b_o      <= DISABLE;
      mem.mem_arb_ram_wr_b_o      <= DISABLE;
      mem.mem_arb_bit_byte_flag_o <= 1'b0;
      mem.mem_arb_ext_ram_o       <= 1'b0;
      mem.mem_arb_rom_addr_o      <= '0;
      mem.mem_arb_ram_addr_o      <= '0;
      mem.mem_arb_ram_data_o      <= '0;
    end else begin
      mem_arb_fetch_ack_o <= 1'b0;
      mem_arb_data_ack_o  <= 1'b0;
      mem_arb_dma_ack_o   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (|grant) begin
            state <= ST_STROBE;
            if (grant[DMA])
              starve_cnt <= '0;
            else if (mem_arb_dma_req_i && starve_cnt != CNT_W'(DMA_STARVE))
              starve_cnt <= starve_cnt + 1'b1;
            if (grant[DATA]) begin
              owner                       <= DATA;
              cmd                         <= mem_arb_data_wr_i ? CMD_RAM_WR : CMD_RAM_RD;
              ext_acc                     <= mem_arb_data_ext_i;
              mem.mem_arb_ram_addr_o      <= mem_arb_data_addr_i;
              mem.mem_arb_ram_data_o      <= mem_arb_data_wdata_i;
              mem.mem_arb_bit_byte_flag_o <= mem_arb_data_bit_i;
              mem.mem_arb_ext_ram_o       <= mem_arb_data_ext_i;
              mem.mem_arb_ram_rd_b_o      <= mem_arb_data_wr_i ? DISABLE : ENABLE;
              mem.mem_arb_ram_wr_b_o      <= mem_arb_data_wr_i ? ENABLE : DISABLE;
            end else if (grant[FETCH]) begin
              owner                       <= FETCH;
              cmd                         <= CMD_ROM_RD;
              ext_acc                     <= ~mem_arb_ea_b_i;
              mem.mem_arb_rom_addr_o      <= mem_arb_fetch_addr_i;
              mem.mem_arb_bit_byte_flag_o <= 1'b0;
              mem.mem_arb_ext_ram_o       <= 1'b0;
              mem.mem_arb_rom_rd_b_o      <= ENABLE;
            end else begin
              owner                       <= DMA;
              cmd                         <= mem_arb_dma_wr_i ? CMD_RAM_WR : CMD_RAM_RD;
              ext_acc                     <= 1'b0;
              mem.mem_arb_ram_addr_o      <= mem_arb_dma_addr_i;
              mem.mem_arb_ram_data_o      <= mem_arb_dma_wdata_i;
              mem.mem_arb_bit_byte_flag_o <= 1'b0;
              mem.mem_arb_ext_ram_o       <= 1'b0;
              mem.mem_arb_ram_rd_b_o      <= mem_arb_dma_wr_i ? DISABLE : ENABLE;
              mem.mem_arb_ram_wr_b_o      <= mem_arb_dma_wr_i ? ENABLE : DISABLE;
            end
          end
        end
        ST_STROBE, ST_WAIT: begin
          if (last_low) begin
            state                  <= ST_ACK;
            mem.mem_arb_rom_rd_b_o <= DISABLE;
            mem.mem_arb_ram_rd_b_o <= DISABLE;
            mem.mem_arb_ram_wr_b_o <= DISABLE;
            mem_arb_fetch_ack_o    <= (owner == FETCH);
            mem_arb_data_ack_o     <= (owner == DATA);
            mem_arb_dma_ack_o      <= (owner == DMA);
            if (cmd == CMD_ROM_RD)      mem_arb_rdata_o <= mem.mem_arb_rom_data_i;
            else if (cmd == CMD_RAM_RD) mem_arb_rdata_o <= mem.mem_arb_ram_data_i;
          end else if (state == ST_STROBE) begin
            state    <= ST_WAIT;
            wait_cnt <= 3'(EXT_WAIT - 1);
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
